// File: rtl/undobuf_tx.sv
// UnDoBuf link transmitter: queues ASIC buffer-clear tags and serializes each as a 4-bit frame.
// Optional frames-sent counter NSent is built only when UNDOBUF_TX_COUNT_EN is defined.
module undobuf_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP          = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     BufClrIn,
  input  logic [1:0]               TagIn,
  output logic                     UnDoBuf,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     OverFlow,
  output logic [15:0]              NSent
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 12;

  typedef enum logic [2:0] {S_IDLE, S_START, S_TG1, S_TG0, S_PAR, S_GAP} state_t;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  state_t        r_state, w_state_nx;
  logic [TW-1:0] r_cnt;
  logic [2:0]    r_shift;
  logic          r_line, w_line_nx;
  logic          w_pop, w_push, w_full, w_bit_last, w_gap_last;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign w_push     = BufClrIn && (!w_full || w_pop);
  assign w_bit_last = (r_cnt == TW'(CLKS_PER_BIT - 1));
  assign w_gap_last = (r_cnt == TW'(GAP * CLKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf   <= BufClrIn && w_full && !w_pop;
    end
  end

  // NOTE: tag storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wptr] <= TagIn;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_line  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_line  <= w_line_nx;
      if (w_state_nx != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
      if (w_pop) r_shift <= {r_mem[r_rptr], ^r_mem[r_rptr]};
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop      = 1'b1;
          w_state_nx = S_START;
        end
      end
      S_START: if (w_bit_last) w_state_nx = S_TG1;
      S_TG1:   if (w_bit_last) w_state_nx = S_TG0;
      S_TG0:   if (w_bit_last) w_state_nx = S_PAR;
      S_PAR:   if (w_bit_last) w_state_nx = S_GAP;
      S_GAP:   if (w_gap_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // The line register is loaded with the bit belonging to the state being entered.
  always_comb begin
    w_line_nx = 1'b0;
    case (w_state_nx)
      S_START: w_line_nx = 1'b1;
      S_TG1:   w_line_nx = r_shift[2];
      S_TG0:   w_line_nx = r_shift[1];
      S_PAR:   w_line_nx = r_shift[0];
      default: w_line_nx = 1'b0;
    endcase
  end

`ifdef UNDOBUF_TX_COUNT_EN
  logic        w_sent;
  logic [15:0] r_nsent;

  assign w_sent = (r_state == S_PAR) && (w_state_nx == S_GAP);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      r_nsent <= '0;
    else if (w_sent) r_nsent <= r_nsent + 16'd1;
  end

  assign NSent = r_nsent;
`else
  assign NSent = '0;
`endif

  assign UnDoBuf  = r_line;
  assign Busy     = (r_state != S_IDLE);
  assign Count    = r_count;
  assign OverFlow = r_ovf;

endmodule

// File: tb/tb_undobuf_tx.sv
// Bench for undobuf_tx: two instances (1 and 3 clocks per bit) checked against a frame-timing model.
// Honours UNDOBUF_TX_COUNT_EN for the expected NSent values.
module tb_undobuf_tx;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int C0    = 1;
  localparam int C1    = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       BufClrIn;
  logic [1:0] TagIn;

  logic        line0, busy0, ovf0, line1, busy1, ovf1;
  logic [2:0]  count0, count1;
  logic [15:0] nsent0, nsent1;

  int checks = 0;
  int errors = 0;
  int ovf_seen0, ovf_seen1;

  undobuf_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(C0), .GAP(GAP)) u_dut (
    .Clock(Clock), .Reset(Reset), .BufClrIn(BufClrIn), .TagIn(TagIn),
    .UnDoBuf(line0), .Busy(busy0), .Count(count0), .OverFlow(ovf0), .NSent(nsent0)
  );

  undobuf_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(C1), .GAP(GAP)) u_dut3 (
    .Clock(Clock), .Reset(Reset), .BufClrIn(BufClrIn), .TagIn(TagIn),
    .UnDoBuf(line1), .Busy(busy1), .Count(count1), .OverFlow(ovf1), .NSent(nsent1)
  );

  always #5 Clock = ~Clock;

  // Reference model: a tag list plus the edge number at which the current frame started.
  logic [1:0] mq   [2][DEPTH];
  int         mqn  [2];
  int         mfs  [2];
  logic [1:0] mtag [2];
  int         mn   [2];
  int         msent[2];
  bit         movf [2];

  function automatic int clks(input int i);
    return (i == 0) ? C0 : C1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mqn[i] = 0; mfs[i] = -1; mtag[i] = 2'b00;
      mn[i] = 0; msent[i] = 0; movf[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input bit clr, input logic [1:0] tag);
    int  c, len, n;
    bit  pop;
    c   = clks(i);
    len = (4 + GAP) * c;
    mn[i]++;
    n   = mn[i];
    pop = ((mfs[i] < 0) || (n >= mfs[i] + len + 1)) && (mqn[i] > 0);
    if (pop) begin
      mtag[i] = mq[i][0];
      for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
      mqn[i]--;
      mfs[i] = n;
    end
    movf[i] = 1'b0;
    if (clr) begin
      if (mqn[i] < DEPTH) begin
        mq[i][mqn[i]] = tag;
        mqn[i]++;
      end else begin
        movf[i] = 1'b1;
      end
    end
    if (mfs[i] >= 0 && n == mfs[i] + 4 * c) msent[i] = (msent[i] + 1) % 65536;
  endtask

  function automatic logic exp_line(input int i);
    int         c, off;
    logic [3:0] f;
    c   = clks(i);
    off = mn[i] - mfs[i];
    if (mfs[i] < 0 || off >= 4 * c) return 1'b0;
    f = {1'b1, mtag[i][1], mtag[i][0], mtag[i][1] ^ mtag[i][0]};
    return f[3 - off / c];
  endfunction

  function automatic logic exp_busy(input int i);
    return (mfs[i] >= 0) && ((mn[i] - mfs[i]) < (4 + GAP) * clks(i));
  endfunction

  function automatic int exp_nsent(input int i);
`ifdef UNDOBUF_TX_COUNT_EN
    return msent[i];
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("line0",  32'(line0),  32'(exp_line(0)));
    chk("busy0",  32'(busy0),  32'(exp_busy(0)));
    chk("count0", 32'(count0), mqn[0]);
    chk("ovf0",   32'(ovf0),   32'(movf[0]));
    chk("nsent0", 32'(nsent0), exp_nsent(0));
    chk("line1",  32'(line1),  32'(exp_line(1)));
    chk("busy1",  32'(busy1),  32'(exp_busy(1)));
    chk("count1", 32'(count1), mqn[1]);
    chk("ovf1",   32'(ovf1),   32'(movf[1]));
    chk("nsent1", 32'(nsent1), exp_nsent(1));
    if (ovf0 === 1'b1) ovf_seen0++;
    if (ovf1 === 1'b1) ovf_seen1++;
  endtask

  // Called at a falling edge: drive, let the rising edge happen, then check at the next falling edge.
  task automatic cycle(input bit clr, input logic [1:0] tag);
    BufClrIn = clr;
    TagIn    = tag;
    @(posedge Clock);
    if (Reset) begin
      model_edge(0, clr, tag);
      model_edge(1, clr, tag);
    end
    @(negedge Clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; BufClrIn = 1'b0; TagIn = 2'b00;
    ovf_seen0 = 0; ovf_seen1 = 0;
    model_reset();
    repeat (3) @(negedge Clock);
    chk("rst_line0",  32'(line0),  0);
    chk("rst_busy0",  32'(busy0),  0);
    chk("rst_count0", 32'(count0), 0);
    chk("rst_ovf0",   32'(ovf0),   0);
    chk("rst_nsent0", 32'(nsent0), 0);
    chk("rst_line1",  32'(line1),  0);
    Reset = 1'b1;
    idle(2);

    // Single frames, then four back-to-back tags.
    cycle(1'b1, 2'b10); idle(30);
    cycle(1'b1, 2'b11); idle(30);
    for (int t = 0; t < 4; t++) cycle(1'b1, 2'(t));
    idle(90);

    // Six consecutive events from a fresh reset: the sixth is dropped.
    do_reset();
    ovf_seen0 = 0; ovf_seen1 = 0;
    for (int k = 0; k < 6; k++) cycle(1'b1, 2'($urandom_range(3)));
    idle(130);
    chk("ovf_pulses0", ovf_seen0, 1);
    chk("ovf_pulses1", ovf_seen1, 1);
`ifdef UNDOBUF_TX_COUNT_EN
    chk("nsent_six0", 32'(nsent0), 5);
`else
    chk("nsent_six0", 32'(nsent0), 0);
`endif

    // Full FIFO with a push landing on the pop edge of the fast instance.
    for (int k = 0; k < 5; k++) cycle(1'b1, 2'($urandom_range(3)));
    idle(3);
    cycle(1'b1, 2'($urandom_range(3)));
    chk("full_pop_count0", 32'(count0), 4);
    chk("full_pop_ovf0",   32'(ovf0),   0);
    idle(130);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) cycle(($urandom_range(4) == 0), 2'($urandom_range(3)));
    idle(130);

    // Reset while the Tg0 bit of tag 01 is on the line.
    cycle(1'b1, 2'b01);
    idle(3);
    chk("pre_rst_line0", 32'(line0), 1);
    Reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_line0",  32'(line0),  0);
    chk("mid_rst_count0", 32'(count0), 0);
    chk("mid_rst_busy0",  32'(busy0),  0);
    chk("mid_rst_line1",  32'(line1),  0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    idle(40);
    cycle(1'b1, 2'($urandom_range(3)));
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
